mult_accumulator: RTL
=====================

MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 4, giving products summed per frame (legal 1..255).
REQ-002 SHALL have parameter ACC_W, default 8, giving accumulator/result width (legal 4..32).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port clr  input  1  synchronous frame abort.
REQ-006 SHALL have port in_valid  input  1  operand pair valid.
REQ-007 SHALL have port in_ready  output  1  block accepts operands.
REQ-008 SHALL have port in_a  input  2  multiplicand, unsigned.
REQ-009 SHALL have port in_b  input  2  multiplier, unsigned.
REQ-010 SHALL have port out_valid  output  1  frame result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port out_sum  output  ACC_W  frame sum of products.
REQ-013 SHALL have port out_ovf  output  1  frame overflowed ACC_W.

Function
REQ-014 SHALL form product p = in_a*in_b as 4-bit unsigned (0..9) via a 2x2 Braun multiplier array, zero-extended to ACC_W.
REQ-015 SHALL implement states IDLE, ACCUM, DRAIN; IDLE -> ACCUM unconditionally on first clock after reset.
REQ-016 SHALL drive in_ready=1 only in ACCUM and out_valid=1 only in DRAIN, both registered.
REQ-017 SHALL accept an operand pair on a rising edge where in_valid && in_ready; acc <= acc+p, count <= count+1.
REQ-018 SHALL, on the accept that makes count equal FRAME_LEN, load out_sum with final acc+p and enter DRAIN; out_valid high the following cycle (1-cycle latency).
REQ-019 SHALL hold out_sum, out_ovf, out_valid stable in DRAIN until out_valid && out_ready at a rising edge.
REQ-020 SHALL, on that output handshake, clear acc, count and internal overflow flag and return to ACCUM; in_ready high next cycle; no operand accepted in DRAIN.
REQ-021 SHALL set the internal overflow flag sticky on any carry out of ACC_W within the frame; out_ovf reflects it with out_sum.
REQ-022 SHALL, on clr=1 at a rising edge in any state, clear acc, count, overflow flag, drop out_valid, enter ACCUM; clr overrides a simultaneous input or output handshake.
REQ-023 SHALL leave out_sum unchanged except on frame completion or reset.

Reset
REQ-024 SHALL, while rst_n=0, force state IDLE, in_ready=0, out_valid=0, out_sum=0, out_ovf=0, acc=0, count=0, regardless of clk.
REQ-025 SHALL discard any partial frame or pending result when rst_n asserts mid-operation.

Configuration
REQ-026 SHALL honour macro MULT_ACCUMULATOR_SATURATE_EN: when defined, acc clamps to 2^ACC_W-1 on overflow and stays clamped for the frame.
REQ-027 SHALL, when MULT_ACCUMULATOR_SATURATE_EN is undefined, wrap acc modulo 2^ACC_W; out_ovf behaviour identical in both builds.

Verification (FRAME_LEN=4, ACC_W=8 unless stated)
REQ-028 SHALL cover: pairs (0,0),(1,1),(1,2),(3,3) back-to-back -> out_valid one cycle after 4th accept, out_sum=12, out_ovf=0.
REQ-029 SHALL cover: out_ready low 5 cycles after out_valid -> out_sum/out_valid held, in_ready=0, in_valid pairs ignored; release -> in_ready=1 next cycle.
REQ-030 SHALL cover: ACC_W=4, FRAME_LEN=2, pairs (3,3),(3,3) -> out_sum=2 out_ovf=1 without macro; out_sum=15 out_ovf=1 with macro.
REQ-031 SHALL cover: two (3,3) accepts, clr pulse, then four (1,1) -> out_sum=4, out_ovf=0.
REQ-032 SHALL cover: rst_n low mid-frame after two accepts and in DRAIN -> all outputs 0 immediately; next frame of four (2,2) -> out_sum=16.
REQ-033 SHALL cover: FRAME_LEN=1, all 16 (in_a,in_b) pairs -> each out_sum equals in_a*in_b, e.g. (3,2) -> 6, (3,3) -> 9.

Source files
------------

// File: rtl/mult_accumulator.sv
// mult_accumulator: frames FRAME_LEN products of 2-bit unsigned operands into an
// ACC_W-bit sum with sticky overflow, valid/ready on both sides.
// Optional build macro MULT_ACCUMULATOR_SATURATE_EN clamps the accumulator at
// 2^ACC_W-1 instead of wrapping.
module mult_accumulator #(
    parameter int FRAME_LEN = 4,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ACC_W:0]   sum;
    logic [7:0]       count;
    logic [3:0]       p;
    logic             ovf;
    logic             carry;
    logic             last;
    logic             c1;

    // 2x2 Braun array: one half adder on the middle column, carry into the top cell
    assign c1   = (in_a[1] & in_b[0]) & (in_a[0] & in_b[1]);
    assign p[0] = in_a[0] & in_b[0];
    assign p[1] = (in_a[1] & in_b[0]) ^ (in_a[0] & in_b[1]);
    assign p[2] = (in_a[1] & in_b[1]) ^ c1;
    assign p[3] = (in_a[1] & in_b[1]) & c1;

    assign sum   = {1'b0, acc} + (ACC_W+1)'(p);
    assign carry = sum[ACC_W];
    assign last  = count == 8'(FRAME_LEN - 1);

`ifdef MULT_ACCUMULATOR_SATURATE_EN
    // once clamped, any further add carries again, so the clamp persists for the frame
    assign acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_next = sum[ACC_W-1:0];
`endif

    // frame control FSM with registered handshake outputs and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= ACCUM;
                    in_ready <= 1'b1;
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc   <= acc_next;
                        ovf   <= ovf | carry;
                        count <= count + 8'd1;
                        if (last) begin
                            out_sum   <= acc_next;
                            out_ovf   <= ovf | carry;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
